// File: rtl/load_store_unit.sv
// Load/store initiator: byte-address requests to word-wide memory, sub-word extract/merge (LSU_BYTE_LANES_EN).
// Latency accept->resp: error 1, load/word store 2, sub-word store 3 cycles.
// Backpressure: req_ready high only in IDLE; one request in flight, no buffering.
module load_store_unit #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 256,
  localparam int AW       = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [MEM_WIDTH-1:0] resp_rdata,
  output logic                 resp_error,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic                 op_write;
  logic                 req_err;
  logic                 size_err;
  logic                 align_err;
  logic                 range_err;
  logic [MEM_WIDTH-1:0] load_ext;

`ifdef LSU_BYTE_LANES_EN
  logic [1:0]           op_size;
  logic                 op_signed;
  logic [1:0]           op_lane;
  logic [15:0]          op_wdata;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [MEM_WIDTH-1:0] merge_word;
`else
  // Sign control and upper store data only matter when sub-word lanes exist.
  logic unused_sub_word;
  assign unused_sub_word = ^{req_signed, req_wdata};
`endif

  // Request legality: size/alignment per build, and address must fall inside the memory.
  always_comb begin
    size_err  = 1'b0;
    align_err = 1'b0;
`ifdef LSU_BYTE_LANES_EN
    size_err  = (req_size == 2'b11);
    align_err = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    size_err  = (req_size != 2'b10);
    align_err = (req_addr[1:0] != 2'b00);
`endif
    range_err = |req_addr[31:AW+2];
    req_err   = size_err || align_err || range_err;
  end

`ifdef LSU_BYTE_LANES_EN
  // Lane extract/extend for loads and lane merge for sub-word stores (little-endian).
  always_comb begin
    byte_sel   = mem_read_val[{op_lane, 3'b000} +: 8];
    half_sel   = mem_read_val[{op_lane[1], 4'b0000} +: 16];
    load_ext   = mem_read_val;
    merge_word = mem_read_val;
    if (op_size == 2'b00) begin
      load_ext = {{24{op_signed & byte_sel[7]}}, byte_sel};
      merge_word[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
    end else if (op_size == 2'b01) begin
      load_ext = {{16{op_signed & half_sel[15]}}, half_sel};
      merge_word[{op_lane[1], 4'b0000} +: 16] = op_wdata;
    end
  end
`else
  // Word-only build: the read word is the load result.
  always_comb begin
    load_ext = mem_read_val;
  end
`endif

  // Next-state selection; a READ on behalf of a store always continues to WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                    state_d = RESP;
          else if (!req_write)            state_d = READ;
          else if (req_size == 2'b10)     state_d = WRITE;
          else                            state_d = READ;
        end
      end
      READ:    state_d = op_write ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from state so reset removes them without waiting for a clock.
  assign req_ready    = (state_q == IDLE);
  assign mem_read_en  = (state_q == READ);
  assign mem_write_en = (state_q == WRITE);
  assign resp_valid   = (state_q == RESP);

  // State register plus request capture, load result and write data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      op_write      <= 1'b0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      resp_rdata    <= '0;
      resp_error    <= 1'b0;
`ifdef LSU_BYTE_LANES_EN
      op_size       <= 2'b00;
      op_signed     <= 1'b0;
      op_lane       <= 2'b00;
      op_wdata      <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_write   <= req_write;
            mem_addr   <= req_addr[AW+1:2];
            resp_rdata <= '0;
            resp_error <= req_err;
`ifdef LSU_BYTE_LANES_EN
            op_size    <= req_size;
            op_signed  <= req_signed;
            op_lane    <= req_addr[1:0];
            op_wdata   <= req_wdata[15:0];
`endif
            if (req_write && (req_size == 2'b10) && !req_err)
              mem_write_val <= req_wdata;
          end
        end
        READ: begin
          if (!op_write)
            resp_rdata <= load_ext;
`ifdef LSU_BYTE_LANES_EN
          else
            mem_write_val <= merge_word;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int MEM_SIZE = 256;
  localparam int AW       = $clog2(MEM_SIZE);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [31:0]   mem_write_val;
  logic [31:0]   mem_read_val;

  load_store_unit #(.MEM_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_val(mem_write_val),
    .mem_read_val(mem_read_val)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT, and an independent reference image.
  logic [31:0] mem     [MEM_SIZE];
  logic [31:0] ref_mem [MEM_SIZE];
  assign mem_read_val = mem[mem_addr];
  always @(posedge clk) if (mem_write_en) mem[mem_addr] <= mem_write_val;

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    int            lat;
    int            nrd;
    int            nwr;
    logic [AW-1:0] idx;
    logic [31:0]   wval;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
    end
  endfunction

  // Reference behaviour straight from the rules: legality, lane arithmetic, latency by kind.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    bit          legal;
    int          lane;
    int          nbytes;
    longint      mask;
    longint      v;
    logic [31:0] word;
    lane   = int'(a[1:0]);
    nbytes = 1 << sz;
`ifdef LSU_BYTE_LANES_EN
    legal = (sz != 2'b11) && (lane % nbytes == 0);
`else
    legal = (sz == 2'b10) && (lane == 0);
`endif
    if ((a >> (AW + 2)) != 0) legal = 0;
    e.idx   = a[AW+1:2];
    e.rdata = '0;
    e.err   = !legal;
    e.wval  = '0;
    e.nrd   = 0;
    e.nwr   = 0;
    e.lat   = 1;
    if (legal) begin
      word = ref_mem[e.idx];
      mask = (64'd1 << (8 * nbytes)) - 1;
      if (!w) begin
        v = (longint'(word) >> (8 * lane)) & mask;
        if (sg && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v | ~mask;
        e.rdata = v[31:0];
        e.lat   = 2;
        e.nrd   = 1;
      end else begin
        v = ((longint'(word) & ~(mask << (8 * lane))) | ((longint'(wd) & mask) << (8 * lane)));
        e.wval  = v[31:0];
        ref_mem[e.idx] = v[31:0];
        e.nwr   = 1;
        e.nrd   = (nbytes < 4) ? 1 : 0;
        e.lat   = (nbytes < 4) ? 3 : 2;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input bit score);
    int   guard;
    exp_t e;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", guard);
      req_valid = 1'b0;
      return;
    end
    if (score) begin
      model(w, sz, sg, a, wd, e);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: protocol invariants each cycle, scoreboard compare on each response.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read_en || mem_write_en || resp_valid) begin
        check("ready_when_busy", {31'd0, req_ready}, 32'd0);
        check("enables_exclusive", {31'd0, mem_read_en & mem_write_en}, 32'd0);
      end
      if (mem_read_en) begin
        rd_cnt++;
        if (sb.size() > 0) check("read_addr", {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, sb[0].idx});
      end
      if (mem_write_en) begin
        wr_cnt++;
        if (sb.size() > 0) begin
          check("write_addr", {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, sb[0].idx});
          check("write_val", mem_write_val, sb[0].wval);
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_error", {31'd0, resp_error}, {31'd0, mon_e.err});
          check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          check("read_cycles", 32'(rd_cnt), 32'(mon_e.nrd));
          check("write_cycles", 32'(wr_cnt), 32'(mon_e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d responses missing", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int   guard;
    logic w;
    logic [1:0] sz;
    logic [31:0] a;
    for (int i = 0; i < MEM_SIZE; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_read_en", {31'd0, mem_read_en}, 32'd0);
    check("rst_write_en", {31'd0, mem_write_en}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_write_val", mem_write_val, 32'd0);
    check("rst_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed sequence, issued back-to-back with req_valid held high.
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h10, 32'h11223344, 1);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 1);
    issue(0, 2'b01, 1, 32'h12, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h10, 32'h80FF0000, 1);
    issue(0, 2'b00, 1, 32'h12, 32'h0, 1);
    issue(0, 2'b01, 0, 32'h12, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h10, 32'h11223344, 1);
    issue(1, 2'b00, 0, 32'h11, 32'h000000AA, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
    issue(0, 2'b01, 0, 32'h11, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h12, 32'h12345678, 1);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 1);
    issue(0, 2'b10, 0, 32'h400, 32'h0, 1);
    issue(0, 2'b00, 0, 32'h10, 32'h0, 1);
    drain();

    // Randomized traffic with idle gaps; small address window to force reuse.
    for (int n = 0; n < 300; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
      w  = 1'($urandom);
      sz = 2'($urandom);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else if ($urandom_range(0, 1) == 0) a = $urandom_range(0, 63);
      else a = $urandom_range(0, MEM_SIZE * 4 - 1);
      issue(w, sz, 1'($urandom), a, $urandom, 1);
    end
    drain();
    for (int i = 0; i < MEM_SIZE; i++)
      if (mem[i] !== ref_mem[i]) check("mem_image", mem[i], ref_mem[i]);
    check("mem_word8", mem[8], ref_mem[8]);

    // Reset during WRITE: the write must be dropped and no response issued.
`ifdef LSU_BYTE_LANES_EN
    issue(1, 2'b00, 0, 32'h21, 32'h0000005A, 0);
`else
    issue(1, 2'b10, 0, 32'h20, 32'h5555AAAA, 0);
`endif
    guard = 0;
    while (!mem_write_en && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("reached_write", {31'd0, mem_write_en}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_write_en", {31'd0, mem_write_en}, 32'd0);
    check("rst_async_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    check("abandoned_write", mem[8], ref_mem[8]);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts one load or store per handshake from the CPU execute/memory stage and drives the word-wide data memory controller's `mem_addr` / `mem_read_en` / `mem_write_en` / `mem_write_val` / `mem_read_val` port set. It converts byte addresses to word indices and extracts and extends sub-word loads. Sub-word stores are performed as a read-modify-write. Misaligned or out-of-range requests are rejected with an error response and no memory access.

## Interface
Parameters:
- `MEM_WIDTH`, 32: memory word width; only 32 is supported.
- `MEM_SIZE`, 256: memory depth in words. `AW = $clog2(MEM_SIZE)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is an error.
- `req_signed`  in  1  loads only: sign-extend (1) or zero-extend (0).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; sub-word data is in the low bits.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result, valid with `resp_valid`; 0 for stores and errors.
- `resp_error`  out  1  misaligned, out-of-range or unsupported request; valid with `resp_valid`.
- `mem_addr`  out  AW  word index, `req_addr[AW+1:2]`.
- `mem_read_en`  out  1  high in READ.
- `mem_write_en`  out  1  high in WRITE.
- `mem_write_val`  out  32  word to write.
- `mem_read_val`  in  32  combinational read data from the memory.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. Reset forces IDLE.
- IDLE: `req_ready=1`. When `req_valid`, the request is registered and the next state is chosen:
  - Error: `req_size` is 11; or a halfword has `addr[0]` set; or a word has `addr[1:0]` nonzero; or `req_addr[31:AW+2]` is nonzero. Next state is RESP with the error flag set.
  - Load: next state is READ.
  - Word store: next state is WRITE, with `mem_write_val = req_wdata`.
  - Sub-word store: next state is READ.
- READ: `mem_read_en=1`, and `mem_read_val` is captured at the end of the cycle.
  - Load: extract the lane selected by `addr[1:0]`. Byte order is little-endian, so byte k is bits `8k+7:8k`. Extend per `req_signed`, then go to RESP.
  - Sub-word store: merge `req_wdata[7:0]` or `[15:0]` into the addressed lane of the captured word to form `mem_write_val`, then go to WRITE.
- WRITE: `mem_write_en=1` for exactly one cycle; next state is RESP.
- RESP: `resp_valid=1` for one cycle, with `resp_rdata` and `resp_error` driven from registers; next state is IDLE.
- `mem_read_en` and `mem_write_en` are never high together, and are never high in IDLE or RESP. An error request produces no memory enable at all.
- `mem_addr` holds the registered word index from the accept cycle until the return to IDLE.
- `req_*` inputs are ignored outside the IDLE handshake.

## Timing
- Handshake: a request is accepted in cycle T when `req_valid && req_ready`. There is no buffering; `req_ready` drops in T+1.
- Latency from accept to `resp_valid`:
  - error: T+1
  - load: T+2
  - word store: T+2
  - sub-word store: T+3
- Throughput:
  - one load or word store every 3 cycles
  - one sub-word store every 4 cycles
  - a new request is accepted no earlier than the cycle after RESP.
- Reset value of every output:
  - `req_ready`: 1
  - `resp_valid`, `resp_error`, `mem_read_en`, `mem_write_en`: 0
  - `resp_rdata`, `mem_write_val`, `mem_addr`: 0
- Reset mid-operation returns the FSM to IDLE immediately. Any pending write is abandoned, and no `resp_valid` is issued for that request.

## Configuration
- Macro: `LSU_BYTE_LANES_EN`.
- Defined: byte and halfword loads and stores are supported as described above.
- Undefined:
  - Only `req_size=10` is legal; any other size gets an error response at T+1.
  - No read-modify-write path is present; the merge and extract logic is removed.
  - Word load and store behaviour and timing are unchanged.

## Test plan
- Reset release, then a word store of 0xDEADBEEF to addr 0x10, then a word load from 0x10. Expect `mem_addr=4`, `mem_write_en` high for one cycle, `resp_valid` at T+2, and the load returning `resp_rdata=0xDEADBEEF` at T+2.
- With word 4 = 0x11223344: a signed byte load at 0x13 returns 0x00000011; a signed halfword load at 0x12 returns 0x00001122. With word 4 = 0x80FF0000: a signed byte load at 0x12 returns 0xFFFFFFFF, and an unsigned halfword load at 0x12 returns 0x000080FF.
- Byte store of 0xAA to 0x11 over word 0x11223344: READ at T+1, WRITE at T+2 with `mem_write_val=0x1122AA44`, `resp_valid` at T+3. A subsequent word load returns 0x1122AA44.
- Error cases: a halfword load at 0x11, a word store at 0x12, `req_size=11`, and addr 0x400 with `MEM_SIZE=256`. Each gives `resp_error=1` and `resp_rdata=0` at T+1, with no memory enable. With `LSU_BYTE_LANES_EN` undefined, a byte load also gives `resp_error=1` at T+1.
- Back-to-back: `req_valid` held high with two queued requests. The second is accepted only after RESP, and `req_ready` is never high outside IDLE.
- `reset` asserted during WRITE of a sub-word store: `mem_write_en` drops asynchronously, no `resp_valid` follows, and `req_ready=1` after reset.
